soc_req_arbiter: RTL and testbench

- Single-outstanding round-robin arbiter that shares the SoC target port between NrMasters requesters.
- Each accepted request is decoded against the fixed SoC address map (Debug, CLINT, DRAM, PERIP) and forwarded downstream with a target select and a widened ID.
- Requests to unmapped addresses are answered locally with an error response.
- Sits between the core/debug masters and the crossbar target side.

---
 rtl/soc_arb_pkg.sv | 30 +++
 rtl/soc_addr_decode.sv | 44 ++++
 rtl/soc_req_arbiter.sv | 219 +++++++++++++++++++++
 tb/tb_soc_req_arbiter.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/soc_arb_pkg.sv
// Shared types and address map for the SoC request arbiter.
// Holds the target-select encoding, the address windows and the arbiter FSM states.
package soc_arb_pkg;

  localparam int unsigned NbTargets = 4;

  typedef enum logic [1:0] {
    TgtDram  = 2'd0,
    TgtPerip = 2'd1,
    TgtClint = 2'd2,
    TgtDebug = 2'd3
  } tgt_e;

  localparam logic [63:0] DebugBase = 64'h0000_0000_0000_0000;
  localparam logic [63:0] DebugLen  = 64'h0000_0000_0000_1000;
  localparam logic [63:0] ClintBase = 64'h0000_0000_0200_0000;
  localparam logic [63:0] ClintLen  = 64'h0000_0000_000C_0000;
  localparam logic [63:0] DramBase  = 64'h0000_0000_8000_0000;
  localparam logic [63:0] DramLen   = 64'h0000_0000_2000_0000;
  localparam logic [63:0] PeripBase = 64'h0000_0000_E000_0000;
  localparam logic [63:0] PeripLen  = 64'h0000_0000_1000_0000;

  typedef enum logic [1:0] {
    StIdle,
    StReq,
    StWait,
    StDecerr
  } state_e;

endpackage

// File: rtl/soc_addr_decode.sv
// Combinational address decoder: maps an address onto one of the SoC targets.
// A miss (hit_o = 0) means the address falls outside every window.
module soc_addr_decode
  import soc_arb_pkg::*;
#(
  parameter int unsigned AddrWidth = 64
) (
  input  logic [AddrWidth-1:0] addr_i,
  output logic                 hit_o,
  output tgt_e                 sel_o
);

  localparam int unsigned ExtW = AddrWidth + 1;

  // Window end is formed one bit wider so base+len never wraps.
  function automatic logic in_range(input logic [ExtW-1:0] a, input logic [63:0] base,
                                    input logic [63:0] len);
    logic [ExtW-1:0] lo;
    logic [ExtW-1:0] hi;
    lo = ExtW'(base);
    hi = ExtW'(base) + ExtW'(len);
    return (a >= lo) && (a < hi);
  endfunction

  logic [ExtW-1:0] addr_ext;
  assign addr_ext = {1'b0, addr_i};

  always_comb begin
    hit_o = 1'b1;
    sel_o = TgtDram;
    if (in_range(addr_ext, DramBase, DramLen)) begin
      sel_o = TgtDram;
    end else if (in_range(addr_ext, PeripBase, PeripLen)) begin
      sel_o = TgtPerip;
    end else if (in_range(addr_ext, ClintBase, ClintLen)) begin
      sel_o = TgtClint;
    end else if (in_range(addr_ext, DebugBase, DebugLen)) begin
      sel_o = TgtDebug;
    end else begin
      hit_o = 1'b0;
    end
  end

endmodule

// File: rtl/soc_req_arbiter.sv
// Single-outstanding round-robin arbiter in front of the SoC target port.
// Optional SOC_ARB_PERF_CNT_EN adds saturating grant / decode-error counters.
module soc_req_arbiter
  import soc_arb_pkg::*;
#(
  parameter int unsigned NrMasters = 2,
  parameter int unsigned IdWidth   = 4,
  parameter int unsigned AddrWidth = 64,
  parameter int unsigned DataWidth = 64
) (
  input  logic                                      clk_i,
  input  logic                                      rst_ni,
  input  logic [NrMasters-1:0]                      m_req_valid_i,
  output logic [NrMasters-1:0]                      m_req_ready_o,
  input  logic [NrMasters*AddrWidth-1:0]            m_req_addr_i,
  input  logic [NrMasters-1:0]                      m_req_we_i,
  input  logic [NrMasters*DataWidth-1:0]            m_req_wdata_i,
  input  logic [NrMasters*DataWidth/8-1:0]          m_req_be_i,
  input  logic [NrMasters*IdWidth-1:0]              m_req_id_i,
  output logic [NrMasters-1:0]                      m_rsp_valid_o,
  output logic [DataWidth-1:0]                      m_rsp_rdata_o,
  output logic                                      m_rsp_err_o,
  output logic [IdWidth-1:0]                        m_rsp_id_o,
  output logic                                      s_req_valid_o,
  input  logic                                      s_req_ready_i,
  output logic [AddrWidth-1:0]                      s_req_addr_o,
  output logic                                      s_req_we_o,
  output logic [DataWidth-1:0]                      s_req_wdata_o,
  output logic [DataWidth/8-1:0]                    s_req_be_o,
  output logic [1:0]                                s_req_sel_o,
  output logic [IdWidth+$clog2(NrMasters)-1:0]      s_req_id_o,
  input  logic                                      s_rsp_valid_i,
  output logic                                      s_rsp_ready_o,
  input  logic [DataWidth-1:0]                      s_rsp_rdata_i,
  input  logic                                      s_rsp_err_i,
`ifdef SOC_ARB_PERF_CNT_EN
  input  logic [IdWidth+$clog2(NrMasters)-1:0]      s_rsp_id_i,
  output logic [NrMasters*32-1:0]                   perf_grant_cnt_o,
  output logic [31:0]                               perf_decerr_cnt_o
`else
  input  logic [IdWidth+$clog2(NrMasters)-1:0]      s_rsp_id_i
`endif
);

  localparam int unsigned MIdxW   = $clog2(NrMasters);
  localparam int unsigned BeWidth = DataWidth / 8;
  localparam int unsigned SIdW    = IdWidth + MIdxW;

  state_e state_q, state_d;

  logic [MIdxW-1:0]     rr_q;
  logic [MIdxW-1:0]     win;
  logic                 win_vld;
  logic                 grant;
  logic [AddrWidth-1:0] win_addr;
  logic                 dec_hit;
  tgt_e                 dec_sel;

  logic [AddrWidth-1:0] addr_q;
  logic                 we_q;
  logic [DataWidth-1:0] wdata_q;
  logic [BeWidth-1:0]   be_q;
  logic [IdWidth-1:0]   id_q;
  logic [MIdxW-1:0]     mst_q;
  tgt_e                 sel_q;
  logic [NrMasters-1:0] mst_oh;

  logic [NrMasters-1:0] rsp_valid_q;
  logic [DataWidth-1:0] rsp_rdata_q;
  logic                 rsp_err_q;
  logic [IdWidth-1:0]   rsp_id_q;

  // Round-robin search starting at the master after the last winner.
  always_comb begin
    win     = '0;
    win_vld = 1'b0;
    for (int unsigned i = 0; i < NrMasters; i++) begin
      if (!win_vld && m_req_valid_i[(32'(rr_q) + i) % NrMasters]) begin
        win     = MIdxW'((32'(rr_q) + i) % NrMasters);
        win_vld = 1'b1;
      end
    end
  end

  // Grants wait for the previous response pulse to drain.
  assign grant    = (state_q == StIdle) && !(|rsp_valid_q) && win_vld;
  assign win_addr = m_req_addr_i[win*AddrWidth +: AddrWidth];

  always_comb begin
    m_req_ready_o = '0;
    if (grant) begin
      m_req_ready_o[win] = 1'b1;
    end
  end

  soc_addr_decode #(
    .AddrWidth(AddrWidth)
  ) u_addr_decode (
    .addr_i(win_addr),
    .hit_o (dec_hit),
    .sel_o (dec_sel)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: begin
        if (grant) begin
          state_d = dec_hit ? StReq : StDecerr;
        end
      end
      StReq: begin
        if (s_req_ready_i) begin
          state_d = StWait;
        end
      end
      StWait: begin
        if (s_rsp_valid_i) begin
          state_d = StIdle;
        end
      end
      StDecerr: state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  assign mst_oh = {{(NrMasters-1){1'b0}}, 1'b1} << mst_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_q        <= '0;
      addr_q      <= '0;
      we_q        <= 1'b0;
      wdata_q     <= '0;
      be_q        <= '0;
      id_q        <= '0;
      mst_q       <= '0;
      sel_q       <= TgtDram;
      rsp_valid_q <= '0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      rsp_id_q    <= '0;
    end else begin
      rsp_valid_q <= '0;
      if (grant) begin
        addr_q  <= win_addr;
        we_q    <= m_req_we_i[win];
        wdata_q <= m_req_wdata_i[win*DataWidth +: DataWidth];
        be_q    <= m_req_be_i[win*BeWidth +: BeWidth];
        id_q    <= m_req_id_i[win*IdWidth +: IdWidth];
        mst_q   <= win;
        sel_q   <= dec_sel;
        rr_q    <= (32'(win) == NrMasters - 1) ? '0 : win + 1'b1;
      end
      if (state_q == StWait && s_rsp_valid_i) begin
        rsp_valid_q <= mst_oh;
        rsp_rdata_q <= s_rsp_rdata_i;
        // A response tagged for another master is flagged rather than misrouted.
        rsp_err_q   <= s_rsp_err_i || (s_rsp_id_i[SIdW-1:IdWidth] != mst_q);
        rsp_id_q    <= s_rsp_id_i[IdWidth-1:0];
      end
      if (state_q == StDecerr) begin
        rsp_valid_q <= mst_oh;
        rsp_rdata_q <= '0;
        rsp_err_q   <= 1'b1;
        rsp_id_q    <= id_q;
      end
    end
  end

  assign s_req_valid_o = (state_q == StReq);
  assign s_rsp_ready_o = (state_q == StWait);
  assign s_req_addr_o  = addr_q;
  assign s_req_we_o    = we_q;
  assign s_req_wdata_o = wdata_q;
  assign s_req_be_o    = be_q;
  assign s_req_sel_o   = sel_q;
  assign s_req_id_o    = {mst_q, id_q};

  assign m_rsp_valid_o = rsp_valid_q;
  assign m_rsp_rdata_o = rsp_rdata_q;
  assign m_rsp_err_o   = rsp_err_q;
  assign m_rsp_id_o    = rsp_id_q;

`ifdef SOC_ARB_PERF_CNT_EN
  logic [31:0] grant_cnt_q [NrMasters];
  logic [31:0] decerr_cnt_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < NrMasters; i++) begin
        grant_cnt_q[i] <= '0;
      end
      decerr_cnt_q <= '0;
    end else if (grant) begin
      if (grant_cnt_q[win] != 32'hFFFF_FFFF) begin
        grant_cnt_q[win] <= grant_cnt_q[win] + 32'd1;
      end
      if (!dec_hit && decerr_cnt_q != 32'hFFFF_FFFF) begin
        decerr_cnt_q <= decerr_cnt_q + 32'd1;
      end
    end
  end

  for (genvar g = 0; g < NrMasters; g++) begin : gen_perf_out
    assign perf_grant_cnt_o[g*32 +: 32] = grant_cnt_q[g];
  end
  assign perf_decerr_cnt_o = decerr_cnt_q;
`endif

endmodule

// File: tb/tb_soc_req_arbiter.sv
// Directed, table-driven bench for soc_req_arbiter (two masters, default widths).
// Covers decode boundaries, stall stability, ID mismatch, fairness and mid-transaction reset.
module tb_soc_req_arbiter;

  logic         clk;
  logic         rst_n;
  logic [1:0]   m_req_valid;
  logic [1:0]   m_req_ready;
  logic [127:0] m_req_addr;
  logic [1:0]   m_req_we;
  logic [127:0] m_req_wdata;
  logic [15:0]  m_req_be;
  logic [7:0]   m_req_id;
  logic [1:0]   m_rsp_valid;
  logic [63:0]  m_rsp_rdata;
  logic         m_rsp_err;
  logic [3:0]   m_rsp_id;
  logic         s_req_valid;
  logic         s_req_ready;
  logic [63:0]  s_req_addr;
  logic         s_req_we;
  logic [63:0]  s_req_wdata;
  logic [7:0]   s_req_be;
  logic [1:0]   s_req_sel;
  logic [4:0]   s_req_id;
  logic         s_rsp_valid;
  logic         s_rsp_ready;
  logic [63:0]  s_rsp_rdata;
  logic         s_rsp_err;
  logic [4:0]   s_rsp_id;
`ifdef SOC_ARB_PERF_CNT_EN
  logic [63:0]  perf_grant_cnt;
  logic [31:0]  perf_decerr_cnt;
`endif

  soc_req_arbiter dut (
    .clk_i            (clk),
    .rst_ni           (rst_n),
    .m_req_valid_i    (m_req_valid),
    .m_req_ready_o    (m_req_ready),
    .m_req_addr_i     (m_req_addr),
    .m_req_we_i       (m_req_we),
    .m_req_wdata_i    (m_req_wdata),
    .m_req_be_i       (m_req_be),
    .m_req_id_i       (m_req_id),
    .m_rsp_valid_o    (m_rsp_valid),
    .m_rsp_rdata_o    (m_rsp_rdata),
    .m_rsp_err_o      (m_rsp_err),
    .m_rsp_id_o       (m_rsp_id),
    .s_req_valid_o    (s_req_valid),
    .s_req_ready_i    (s_req_ready),
    .s_req_addr_o     (s_req_addr),
    .s_req_we_o       (s_req_we),
    .s_req_wdata_o    (s_req_wdata),
    .s_req_be_o       (s_req_be),
    .s_req_sel_o      (s_req_sel),
    .s_req_id_o       (s_req_id),
    .s_rsp_valid_i    (s_rsp_valid),
    .s_rsp_ready_o    (s_rsp_ready),
    .s_rsp_rdata_i    (s_rsp_rdata),
    .s_rsp_err_i      (s_rsp_err),
`ifdef SOC_ARB_PERF_CNT_EN
    .s_rsp_id_i       (s_rsp_id),
    .perf_grant_cnt_o (perf_grant_cnt),
    .perf_decerr_cnt_o(perf_decerr_cnt)
`else
    .s_rsp_id_i       (s_rsp_id)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        mst;
    logic [63:0] addr;
    logic        we;
    logic [3:0]  id;
    logic        hit;
    logic [1:0]  sel;
    logic [63:0] rdata;
    logic        err;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_req(input int m, input logic [63:0] a, input logic we,
                           input logic [63:0] wd, input logic [7:0] be, input logic [3:0] id);
    m_req_valid[m]           = 1'b1;
    m_req_addr[m*64 +: 64]   = a;
    m_req_we[m]              = we;
    m_req_wdata[m*64 +: 64]  = wd;
    m_req_be[m*8 +: 8]       = be;
    m_req_id[m*4 +: 4]       = id;
  endtask

  task automatic chk_small_outputs_zero(input string name);
    chk(name, {37'd0, m_req_ready, m_rsp_valid, m_rsp_err, m_rsp_id, s_req_valid, s_req_we,
               s_req_be, s_req_sel, s_req_id, s_rsp_ready}, 64'd0);
    chk({name, "_addr"}, s_req_addr, 64'd0);
    chk({name, "_wdata"}, s_req_wdata, 64'd0);
    chk({name, "_rdata"}, m_rsp_rdata, 64'd0);
  endtask

  task automatic run_vec(input vec_t v);
    logic [4:0] sid;
    sid = {v.mst, v.id};
    drive_req(int'(v.mst), v.addr, v.we, ~v.addr, 8'hA5, v.id);
    #1;
    chk("grant", {62'd0, m_req_ready}, 64'(2'b01 << v.mst));
    step();
    m_req_valid = '0;
    chk("s_req_valid_lat1", {63'd0, s_req_valid}, {63'd0, v.hit});
    if (v.hit) begin
      chk("s_req_sel", {62'd0, s_req_sel}, {62'd0, v.sel});
      chk("s_req_addr", s_req_addr, v.addr);
      chk("s_req_id", {59'd0, s_req_id}, {59'd0, sid});
      chk("s_req_wdata", s_req_wdata, ~v.addr);
      s_req_ready = 1'b1;
      step();
      s_req_ready = 1'b0;
      chk("s_rsp_ready_wait", {63'd0, s_rsp_ready}, 64'd1);
      s_rsp_valid = 1'b1;
      s_rsp_rdata = v.rdata;
      s_rsp_err   = v.err;
      s_rsp_id    = sid;
      step();
      s_rsp_valid = 1'b0;
      chk("m_rsp_valid", {62'd0, m_rsp_valid}, 64'(2'b01 << v.mst));
      chk("m_rsp_rdata", m_rsp_rdata, v.rdata);
      chk("m_rsp_err", {63'd0, m_rsp_err}, {63'd0, v.err});
      chk("m_rsp_id", {60'd0, m_rsp_id}, {60'd0, v.id});
    end else begin
      step();
      chk("decerr_no_s_req", {63'd0, s_req_valid}, 64'd0);
      chk("decerr_rsp_valid", {62'd0, m_rsp_valid}, 64'(2'b01 << v.mst));
      chk("decerr_err", {63'd0, m_rsp_err}, 64'd1);
      chk("decerr_rdata", m_rsp_rdata, 64'd0);
      chk("decerr_id", {60'd0, m_rsp_id}, {60'd0, v.id});
    end
    step();
    chk("rsp_pulse_end", {62'd0, m_rsp_valid}, 64'd0);
  endtask

  initial begin
    int n;
    int cyc;

    vecs[0]  = '{1'b0, 64'h8000_0010,   1'b0, 4'h3, 1'b1, 2'd0, 64'hDEAD_BEEF, 1'b0};
    vecs[1]  = '{1'b0, 64'h4000_0000,   1'b0, 4'h5, 1'b0, 2'd0, 64'h0,         1'b0};
    vecs[2]  = '{1'b1, 64'h0000_0FFF,   1'b0, 4'h7, 1'b1, 2'd3, 64'h0123_4567_89AB_CDEF, 1'b0};
    vecs[3]  = '{1'b0, 64'h0000_1000,   1'b1, 4'h2, 1'b0, 2'd0, 64'h0,         1'b0};
    vecs[4]  = '{1'b1, 64'hEFFF_FFF8,   1'b0, 4'h9, 1'b1, 2'd1, 64'hCAFE,      1'b1};
    vecs[5]  = '{1'b1, 64'hF000_0000,   1'b0, 4'hA, 1'b0, 2'd0, 64'h0,         1'b0};
    vecs[6]  = '{1'b0, 64'h0200_0000,   1'b0, 4'h1, 1'b1, 2'd2, 64'h55,        1'b0};
    vecs[7]  = '{1'b0, 64'h020C_0000,   1'b0, 4'h4, 1'b0, 2'd0, 64'h0,         1'b0};
    vecs[8]  = '{1'b1, 64'h9FFF_FFFF,   1'b1, 4'hF, 1'b1, 2'd0, 64'h0,         1'b0};
    vecs[9]  = '{1'b0, 64'hA000_0000,   1'b0, 4'h6, 1'b0, 2'd0, 64'h0,         1'b0};
    vecs[10] = '{1'b0, 64'h1_8000_0000, 1'b0, 4'h0, 1'b0, 2'd0, 64'h0,         1'b0};
    vecs[11] = '{1'b1, 64'hDFFF_FFFF,   1'b0, 4'h8, 1'b0, 2'd0, 64'h0,         1'b0};

    rst_n       = 1'b0;
    m_req_valid = '0;
    m_req_addr  = '0;
    m_req_we    = '0;
    m_req_wdata = '0;
    m_req_be    = '0;
    m_req_id    = '0;
    s_req_ready = 1'b0;
    s_rsp_valid = 1'b0;
    s_rsp_rdata = '0;
    s_rsp_err   = 1'b0;
    s_rsp_id    = '0;
    step();
    step();
    chk_small_outputs_zero("reset_state");
    rst_n = 1'b1;
    step();

    for (int i = 0; i < 12; i++) begin
      run_vec(vecs[i]);
    end

    // M1 write stalled downstream for five cycles; also returns a foreign master tag.
    drive_req(1, 64'h0200_4000, 1'b1, 64'h0102_0304_0506_0708, 8'hFF, 4'hC);
    #1;
    chk("wr_grant", {62'd0, m_req_ready}, 64'd2);
    step();
    m_req_valid = '0;
    m_req_addr  = '0;
    m_req_we    = '0;
    m_req_wdata = '1;
    for (int k = 0; k < 5; k++) begin
      chk("stall_valid", {63'd0, s_req_valid}, 64'd1);
      chk("stall_addr", s_req_addr, 64'h0200_4000);
      chk("stall_wdata", s_req_wdata, 64'h0102_0304_0506_0708);
      chk("stall_ctrl", {48'd0, s_req_be, s_req_we, s_req_sel, s_req_id}, {48'd0, 8'hFF, 1'b1,
                                                                           2'd2, 5'h1C});
      step();
    end
    s_req_ready = 1'b1;
    step();
    s_req_ready = 1'b0;
    s_rsp_valid = 1'b1;
    s_rsp_rdata = 64'h1234;
    s_rsp_err   = 1'b0;
    s_rsp_id    = 5'h0C;
    step();
    s_rsp_valid = 1'b0;
    chk("mismatch_valid", {62'd0, m_rsp_valid}, 64'd2);
    chk("mismatch_err", {63'd0, m_rsp_err}, 64'd1);
    chk("mismatch_id", {60'd0, m_rsp_id}, 64'hC);
    step();

    // Stray downstream response while idle.
    s_rsp_valid = 1'b1;
    #1;
    chk("stray_ready", {63'd0, s_rsp_ready}, 64'd0);
    step();
    s_rsp_valid = 1'b0;
    chk("stray_no_rsp", {62'd0, m_rsp_valid}, 64'd0);

    // Fairness from a fresh reset: both masters request continuously.
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    drive_req(0, 64'h8000_0000, 1'b0, 64'h11, 8'h0F, 4'h1);
    drive_req(1, 64'hE000_0000, 1'b1, 64'h22, 8'hF0, 4'h2);
    s_req_ready = 1'b1;
    s_rsp_valid = 1'b1;
    s_rsp_rdata = 64'h77;
    s_rsp_id    = 5'h00;
    #1;
    n   = 0;
    cyc = 0;
    while (n < 8 && cyc < 200) begin
      if (m_req_ready != 2'b00) begin
        chk("rr_grant", {62'd0, m_req_ready}, (n % 2 == 0) ? 64'd1 : 64'd2);
        n++;
      end
      step();
      cyc++;
    end
    chk("rr_grant_count", 64'(n), 64'd8);
`ifdef SOC_ARB_PERF_CNT_EN
    chk("perf_grant_m0", {32'd0, perf_grant_cnt[31:0]}, 64'd4);
    chk("perf_grant_m1", {32'd0, perf_grant_cnt[63:32]}, 64'd4);
    chk("perf_decerr", {32'd0, perf_decerr_cnt}, 64'd0);
`endif
    m_req_valid = '0;
    for (int k = 0; k < 6; k++) begin
      step();
    end
    s_req_ready = 1'b0;
    s_rsp_valid = 1'b0;
    step();

    // M0 goes to WAIT (round-robin now points at M1), then reset mid-transaction.
    drive_req(0, 64'h8000_0100, 1'b1, 64'hFFFF, 8'hFF, 4'h3);
    step();
    m_req_valid = '0;
    s_req_ready = 1'b1;
    step();
    s_req_ready = 1'b0;
    chk("pre_reset_wait", {63'd0, s_rsp_ready}, 64'd1);
    rst_n = 1'b0;
    #1;
    chk_small_outputs_zero("reset_in_wait");
    #3;
    rst_n = 1'b1;
    step();
    drive_req(0, 64'h8000_0200, 1'b0, 64'h0, 8'h01, 4'h4);
    drive_req(1, 64'h0200_0008, 1'b0, 64'h0, 8'h01, 4'h6);
    #1;
    chk("rr_restart_m0_first", {62'd0, m_req_ready}, 64'd1);
    m_req_valid[0] = 1'b0;
    #1;
    chk("post_reset_m1_grant", {62'd0, m_req_ready}, 64'd2);
    step();
    m_req_valid = '0;
    chk("post_reset_s_valid", {63'd0, s_req_valid}, 64'd1);
    chk("post_reset_s_id", {59'd0, s_req_id}, 64'h16);
    chk("post_reset_s_sel", {62'd0, s_req_sel}, 64'd2);
    s_req_ready = 1'b1;
    step();
    s_req_ready = 1'b0;
    s_rsp_valid = 1'b1;
    s_rsp_rdata = 64'hABCD;
    s_rsp_err   = 1'b0;
    s_rsp_id    = 5'h16;
    step();
    s_rsp_valid = 1'b0;
    chk("post_reset_rsp", {62'd0, m_rsp_valid}, 64'd2);
    chk("post_reset_rdata", m_rsp_rdata, 64'hABCD);
    chk("post_reset_err", {63'd0, m_rsp_err}, 64'd0);
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
